uart_txp: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO, an on-chip baud divider, optional parity and configurable stop bits. It replaces the external transmit-tick and single-byte empty-flag scheme with a write-strobe FIFO interface and a self-timed serialiser. It sits between the bus-side register file, which pushes bytes, and the TX pad, which carries the serial line.

---
 rtl/uart_txp.sv | 255 +++++++++++++++++++++++++
 tb/tb_uart_txp.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_txp.sv
// uart_txp: UART transmitter with transmit FIFO, baud divider,
// optional parity (UART_TXP_PARITY_EN) and 1 or 2 stop bits.
module uart_txp #(
    parameter int WIDTH_DATA = 8,
    parameter int NB_STOP    = 2,
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH_DIV  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [WIDTH_DATA-1:0] i_data,
    input  logic [WIDTH_DIV-1:0]  i_div,
    input  logic                  i_par_en,
    input  logic                  i_par_odd,
    output logic                  o_tx,
    output logic                  o_full,
    output logic                  o_mty,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_ovf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0] LVL_FULL =
        {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TXP_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [3:0] LAST_DATA = 4'(WIDTH_DATA - 1);
    localparam logic [3:0] LAST_STOP = 4'(NB_STOP - 1);

    // FIFO storage and bookkeeping
    logic [WIDTH_DATA-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  ovf_q, ovf_d;

    // Serialiser state
    logic [2:0]            state_q, state_d;
    logic [WIDTH_DIV-1:0]  cnt_q, cnt_d;
    logic [WIDTH_DIV-1:0]  div_q, div_d;
    logic [3:0]            bit_q, bit_d;
    logic [WIDTH_DATA-1:0] sh_q, sh_d;
    logic                  tx_q, tx_d;

`ifdef UART_TXP_PARITY_EN
    logic                  pen_q, pen_d;
    logic                  podd_q, podd_d;
    logic                  par_q, par_d;
`else
    logic                  unused_par;
    assign unused_par = i_par_en ^ i_par_odd;
`endif

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic load;
    logic bit_end;

    assign full    = (level_q == LVL_FULL);
    assign empty   = (level_q == '0);
    assign push    = i_we & ~full;
    assign bit_end = (cnt_q == div_q);

    // FIFO pointers, occupancy and overflow pulse
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = i_we & full;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Frame sequencer: start, data, optional parity, stop bits
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        div_d   = div_q;
        pop     = 1'b0;
        load    = 1'b0;
`ifdef UART_TXP_PARITY_EN
        pen_d   = pen_q;
        podd_d  = podd_q;
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    sh_d  = sh_q >> 1;
`ifdef UART_TXP_PARITY_EN
                    par_d = par_q ^ sh_q[0];
`endif
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
`ifdef UART_TXP_PARITY_EN
                        state_d = pen_q ? S_PARITY
                                        : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_TXP_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == LAST_STOP) begin
                        bit_d = '0;
                        if (!empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (load) begin
            pop     = 1'b1;
            sh_d    = mem_q[rptr_q];
            div_d   = i_div;
            cnt_d   = '0;
            bit_d   = '0;
            state_d = S_START;
`ifdef UART_TXP_PARITY_EN
            pen_d   = i_par_en;
            podd_d  = i_par_odd;
            par_d   = 1'b0;
`endif
        end
    end

    // Line level for the state being entered, so o_tx is a flop
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = sh_d[0];
`ifdef UART_TXP_PARITY_EN
            S_PARITY: tx_d = par_d ^ podd_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // FIFO array write; contents need no reset
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wptr_q] <= i_data;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TXP_PARITY_EN
            pen_q   <= 1'b0;
            podd_q  <= 1'b0;
            par_q   <= 1'b0;
`endif
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
`ifdef UART_TXP_PARITY_EN
            pen_q   <= pen_d;
            podd_q  <= podd_d;
            par_q   <= par_d;
`endif
        end
    end

    assign o_tx    = tx_q;
    assign o_full  = full;
    assign o_mty   = empty && (state_q == S_IDLE);
    assign o_level = level_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_uart_txp.sv
// tb_uart_txp: checks uart_txp against a frame-queue model
// plus directed vectors and corner-case sequences.
module tb_uart_txp;

    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int NB_STOP    = 2;
`ifdef UART_TXP_PARITY_EN
    localparam bit PAR_BUILT  = 1'b1;
`else
    localparam bit PAR_BUILT  = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                we = 1'b0;
    logic [7:0]          data = 8'h00;
    logic [15:0]         div = 16'd0;
    logic                pen = 1'b0;
    logic                podd = 1'b0;
    logic                tx;
    logic                full;
    logic                mty;
    logic [DEPTH_LOG2:0] level;
    logic                ovf;

    uart_txp #(
        .WIDTH_DATA(8),
        .NB_STOP(NB_STOP),
        .DEPTH_LOG2(DEPTH_LOG2),
        .WIDTH_DIV(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_we(we),
        .i_data(data),
        .i_div(div),
        .i_par_en(pen),
        .i_par_odd(podd),
        .o_tx(tx),
        .o_full(full),
        .o_mty(mty),
        .o_level(level),
        .o_ovf(ovf)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int cyc_n = 0;

    // Reference model: queued bytes and the expected line waveform
    logic [7:0] fq[$];
    bit         wq[$];
    bit         m_took = 1'b0;
    bit         m_tx = 1'b1;
    bit         m_ovf = 1'b0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic build_frame(input logic [7:0] d);
        bit bits[$];
        int rep;
        rep = int'(div) + 1;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (PAR_BUILT && pen) bits.push_back((^d) ^ podd);
        for (int i = 0; i < NB_STOP; i++) bits.push_back(1'b1);
        foreach (bits[i])
            for (int r = 0; r < rep; r++) wq.push_back(bits[i]);
    endtask

    task automatic model_step();
        int  pre;
        bit  acc;
        if (rst) begin
            fq.delete();
            wq.delete();
            m_tx   = 1'b1;
            m_ovf  = 1'b0;
            m_took = 1'b0;
        end else begin
            pre = fq.size();
            acc = we && (pre < DEPTH);
            m_took = 1'b0;
            if (wq.size() == 0 && pre > 0) build_frame(fq.pop_front());
            if (wq.size() > 0) begin
                m_tx = wq.pop_front();
                m_took = 1'b1;
            end else begin
                m_tx = 1'b1;
            end
            if (acc) fq.push_back(data);
            m_ovf = we && !acc;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        cyc_n++;
        #1;
        check("m_tx", tx, m_tx);
        check("m_level", level, fq.size());
        check("m_full", full, fq.size() == DEPTH);
        check("m_mty", mty, (fq.size() == 0) && !m_took);
        check("m_ovf", ovf, m_ovf);
    endtask

    task automatic frame_test(input logic [7:0] d, input bit odd,
                              input int exp_bit, input int exp_len,
                              input string tag);
        int   n;
        logic pb;
        n = 0;
        pb = 1'bx;
        div = 16'd0;
        pen = 1'b1;
        podd = odd;
        we = 1'b1;
        data = d;
        cyc();
        we = 1'b0;
        cyc();
        check({tag, "_start"}, tx, 0);
        while (mty !== 1'b1 && n < 50) begin
            cyc();
            n++;
            if (n == 9) pb = tx;
        end
        check({tag, "_bit9"}, pb, exp_bit);
        check({tag, "_len"}, n, exp_len);
        pen = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        bit          we;
        logic [7:0]  d;
        logic [15:0] dv;
        bit          tx;
        int          lvl;
        bit          mty;
    } vec_t;

    vec_t tbl[14];

    initial begin : main
        int   n;
        int   ovfc;
        int   t_start;
        int   t0;
        int   zeros;
        logic [7:0] a5 = 8'hA5;

        // Reset, push 0x01 at div 0, full frame and return to idle
        tbl[0] = '{1'b1, 1'b0, 8'h00, 16'd0, 1'b1, 0, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 8'h01, 16'd0, 1'b1, 1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 16'd0, 1'b0, 0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 16'd0, 1'b1, 0, 1'b0};
        for (int i = 4; i <= 10; i++)
            tbl[i] = '{1'b0, 1'b0, 8'h00, 16'd0, 1'b0, 0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 16'd0, 1'b1, 0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 16'd0, 1'b1, 0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 16'd0, 1'b1, 0, 1'b1};

        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst;
            we = tbl[i].we;
            data = tbl[i].d;
            div = tbl[i].dv;
            cyc();
            check($sformatf("vec%0d_tx", i), tx, tbl[i].tx);
            check($sformatf("vec%0d_lvl", i), level, tbl[i].lvl);
            check($sformatf("vec%0d_mty", i), mty, tbl[i].mty);
        end

        // Idle for 100 cycles
        for (int i = 0; i < 100; i++) cyc();
        check("idle_tx", tx, 1);
        check("idle_mty", mty, 1);
        check("idle_lvl", level, 0);

        // 8N2, div 3, byte 0xA5
        div = 16'd3;
        we = 1'b1;
        data = a5;
        cyc();
        we = 1'b0;
        check("a5_pre", tx, 1);
        cyc();
        check("a5_start", tx, 0);
        n = 0;
        while (mty !== 1'b1 && n < 100) begin
            cyc();
            n++;
            if (n >= 4 && n < 36 && ((n - 4) % 4) == 1)
                check($sformatf("a5_bit%0d", (n - 4) / 4),
                      tx, a5[(n - 4) / 4]);
            if (n == 36 || n == 43) check("a5_stop", tx, 1);
        end
        check("a5_mty_delay", n, 44);

        // Overflow: six pushes into a depth-4 FIFO, div 9
        div = 16'd9;
        ovfc = 0;
        t_start = 0;
        for (int i = 0; i < 6; i++) begin
            we = 1'b1;
            data = 8'($urandom);
            cyc();
            if (ovf === 1'b1) ovfc++;
            if (i == 1) begin
                t_start = cyc_n;
                check("ovf_start", tx, 0);
            end
        end
        we = 1'b0;
        check("ovf_level", level, 4);
        check("ovf_full", full, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (ovf === 1'b1) ovfc++;
        end
        check("ovf_pulses", ovfc, 1);
        n = 0;
        while (mty !== 1'b1 && n < 1000) begin
            cyc();
            n++;
        end
        check("ovf_span", cyc_n - t_start, 550);

        // Parity on byte 0x07, div 0
        if (PAR_BUILT) begin
            frame_test(8'h07, 1'b0, 1, 12, "par_even");
            frame_test(8'h07, 1'b1, 0, 12, "par_odd");
        end else begin
            frame_test(8'h07, 1'b0, 1, 11, "nopar_even");
            frame_test(8'h07, 1'b1, 1, 11, "nopar_odd");
        end

        // Reset in the middle of the second of three frames
        div = 16'd3;
        pen = 1'b0;
        t0 = cyc_n;
        for (int i = 0; i < 3; i++) begin
            we = 1'b1;
            data = 8'($urandom);
            cyc();
        end
        we = 1'b0;
        while (cyc_n < t0 + 55) cyc();
        check("rst_pre_lvl", level, 1);
        check("rst_pre_busy", mty, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_tx", tx, 1);
        check("rst_lvl", level, 0);
        zeros = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (tx !== 1'b1) zeros++;
        end
        check("rst_quiet", zeros, 0);
        check("rst_mty", mty, 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            we = ($urandom_range(0, 3) == 0);
            data = 8'($urandom);
            if ($urandom_range(0, 19) == 0)
                div = 16'($urandom_range(0, 3));
            pen = 1'($urandom);
            podd = 1'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            cyc();
        end
        rst = 1'b0;
        we = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
